// File: rtl/cpu_mon_pkg.sv
// Shared types and default sizing for the cpu check monitor.
package cpu_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    QUAL,
    FAULT,
    REPORT,
    WAIT_LOW
  } state_e;

  localparam int unsigned DEF_QUAL_CYCLES = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_TS_W        = 16;
  localparam int unsigned QUAL_W          = 8;

endpackage

// File: rtl/cpu_check_monitor.sv
// Debounces the cpu sig/checker condition into counted, timestamped fault
// reports delivered over a valid/ready handshake.
module cpu_check_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES = DEF_QUAL_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TS_W        = DEF_TS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             cpu_sig_i,
  input  logic             cpu_checker_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [CNT_W-1:0] rpt_count_o,
  output logic [TS_W-1:0]  rpt_ts_o,
  output logic             fault_o,
  output logic             busy_o
);

  state_e             state_q, state_d;
  logic [QUAL_W-1:0]  qual_q, qual_d;
  logic [TS_W-1:0]    ts_q;
  logic [TS_W-1:0]    ts_first_q;
  logic [CNT_W-1:0]   fault_cnt_q;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               hit_c;
  logic               capture_c;

  assign hit_c     = cpu_sig_i & cpu_checker_i;
  assign cnt_inc_c = (fault_cnt_q == {CNT_W{1'b1}}) ? fault_cnt_q
                                                    : fault_cnt_q + CNT_W'(1);

  // Next-state and qualification counter
  always_comb begin
    state_d   = state_q;
    qual_d    = qual_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = ARMED;
      end
      ARMED: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (hit_c) begin
          capture_c = 1'b1;
          if (QUAL_CYCLES == 1) begin
            state_d = FAULT;
          end else begin
            state_d = QUAL;
            qual_d  = QUAL_W'(1);
          end
        end
      end
      QUAL: begin
        if (!en_i) begin
          state_d = IDLE;
          qual_d  = '0;
        end else if (!hit_c) begin
          state_d = ARMED;
          qual_d  = '0;
        end else begin
          qual_d = qual_q + QUAL_W'(1);
          if (qual_d == QUAL_W'(QUAL_CYCLES)) state_d = FAULT;
        end
      end
      FAULT: begin
        state_d = REPORT;
        qual_d  = '0;
      end
      REPORT: begin
        if (rpt_ready_i) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!hit_c) state_d = en_i ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timestamp and qualification registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      qual_q     <= '0;
      ts_q       <= '0;
      ts_first_q <= '0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      if (en_i)      ts_q       <= ts_q + TS_W'(1);
      if (capture_c) ts_first_q <= ts_q;
    end
  end

  // Fault accounting; clear takes priority over a coincident fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt_q <= '0;
      fault_o     <= 1'b0;
    end else if (clr_i) begin
      fault_cnt_q <= '0;
      fault_o     <= 1'b0;
    end else if (state_q == FAULT) begin
      fault_cnt_q <= cnt_inc_c;
      fault_o     <= 1'b1;
    end
  end

  // Report payload and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_count_o <= '0;
      rpt_ts_o    <= '0;
      rpt_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (state_q == FAULT) begin
        rpt_count_o <= cnt_inc_c;
        rpt_ts_o    <= ts_first_q;
      end
      rpt_valid_o <= (state_d == REPORT);
      busy_o      <= !(state_d == IDLE || state_d == ARMED);
    end
  end

endmodule

// File: tb/tb_cpu_check_monitor.sv
// Directed bench for cpu_check_monitor with a CNT_W=2 twin for saturation.
module tb_cpu_check_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, sig, chk, ready;
  logic        valid, fault, busy;
  logic [7:0]  count;
  logic [15:0] ts;
  logic        valid2, fault2, busy2;
  logic [1:0]  count2;
  logic [15:0] ts2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_check_monitor #(.QUAL_CYCLES(4), .CNT_W(8), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr),
    .cpu_sig_i(sig), .cpu_checker_i(chk),
    .rpt_valid_o(valid), .rpt_ready_i(ready),
    .rpt_count_o(count), .rpt_ts_o(ts),
    .fault_o(fault), .busy_o(busy)
  );

  cpu_check_monitor #(.QUAL_CYCLES(4), .CNT_W(2), .TS_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr),
    .cpu_sig_i(sig), .cpu_checker_i(chk),
    .rpt_valid_o(valid2), .rpt_ready_i(ready),
    .rpt_count_o(count2), .rpt_ts_o(ts2),
    .fault_o(fault2), .busy_o(busy2)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sig = 1'b0; chk = 1'b0; ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; sig = 1'b1; chk = 1'b1; ready = 1'b1;
    step(3);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (ts !== 16'd0) begin n_err++; $display("FAIL reset_ts got=%0d exp=0", ts); end
  endtask

  task automatic test_qualified();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step(10);
    sig = 1'b1; chk = 1'b1;
    step(4);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL qual_valid_early got=%b exp=0", valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL qual_busy_fault got=%b exp=1", busy); end
    sig = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL qual_valid got=%b exp=1", valid); end
    n_cmp++; if (count !== 8'd1) begin n_err++; $display("FAIL qual_count got=%0d exp=1", count); end
    n_cmp++; if (ts !== 16'd10) begin n_err++; $display("FAIL qual_ts got=%0d exp=10", ts); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL qual_fault got=%b exp=1", fault); end
    step();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL qual_valid_drop got=%b exp=0", valid); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL qual_rearm_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step(3);
    sig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sig_only_%0d got=valid:%b busy:%b exp=0,0", i, valid, busy); end
    end
    chk = 1'b1;
    step(3);
    chk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (valid !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL glitch_%0d got=valid:%b fault:%b exp=0,0", i, valid, fault); end
    end
    chk = 1'b1;
    step(4);
    chk = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL glitch2_valid got=%b exp=1", valid); end
    n_cmp++; if (count !== 8'd1) begin n_err++; $display("FAIL glitch2_count got=%0d exp=1", count); end
    n_cmp++; if (ts !== 16'd14) begin n_err++; $display("FAIL glitch2_ts got=%0d exp=14", ts); end
  endtask

  task automatic test_backpressure();
    int highs;
    do_reset();
    en = 1'b1;
    step(2);
    sig = 1'b1; chk = 1'b1;
    step(5);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (valid !== 1'b1 || count !== 8'd1 || ts !== 16'd2) begin n_err++; $display("FAIL bp_hold_%0d got=v:%b c:%0d t:%0d exp=1,1,2", i, valid, count, ts); end
      en  = (i == 1) ? 1'b0 : 1'b1;
      clr = (i == 3) ? 1'b1 : 1'b0;
      step();
    end
    clr = 1'b0;
    n_cmp++; if (valid !== 1'b1 || count !== 8'd1 || ts !== 16'd2) begin n_err++; $display("FAIL bp_hold_end got=v:%b c:%0d t:%0d exp=1,1,2", valid, count, ts); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL bp_clr_fault got=%b exp=0", fault); end
    ready = 1'b1;
    step();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL bp_accept got=%b exp=0", valid); end
    highs = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (valid) highs++;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_wait_low_%0d got=%b exp=1", i, busy); end
    end
    n_cmp++; if (highs !== 0) begin n_err++; $display("FAIL bp_single_accept got=%0d exp=0", highs); end
    chk = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b exp=0", busy); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    do_reset();
    en = 1'b1; ready = 1'b1;
    step(2);
    for (int e = 0; e < 5; e++) begin
      exp2 = (e >= 2) ? 2'd3 : 2'(e + 1);
      sig = 1'b1; chk = 1'b1;
      step(4);
      chk = 1'b0;
      step();
      n_cmp++; if (valid2 !== 1'b1 || count2 !== exp2) begin n_err++; $display("FAIL sat_w2_%0d got=v:%b c:%0d exp=1,%0d", e, valid2, count2, exp2); end
      n_cmp++; if (valid !== 1'b1 || count !== 8'(e + 1)) begin n_err++; $display("FAIL sat_w8_%0d got=v:%b c:%0d exp=1,%0d", e, valid, count, e + 1); end
      step(3);
    end
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1;
    step(2);
    sig = 1'b1; chk = 1'b1;
    step(4);
    n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL clr_in_fault got=b:%b v:%b exp=1,0", busy, valid); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL clr_valid got=%b exp=1", valid); end
    n_cmp++; if (count !== 8'd1) begin n_err++; $display("FAIL clr_payload got=%0d exp=1", count); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL clr_fault got=%b exp=0", fault); end
    chk = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    step(2);
    chk = 1'b1;
    step(4);
    chk = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b1 || count !== 8'd1) begin n_err++; $display("FAIL clr_next_count got=v:%b c:%0d exp=1,1", valid, count); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL clr_next_fault got=%b exp=1", fault); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got=%b exp=0", valid); end
    n_cmp++; if (busy !== 1'b0 || fault !== 1'b0 || count !== 8'd0) begin n_err++; $display("FAIL async_rst_state got=b:%b f:%b c:%0d exp=0,0,0", busy, fault, count); end
    rst_n = 1'b1;
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    step(2);
    sig = 1'b1; chk = 1'b1;
    step(2);
    en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL en_drop_%0d got=v:%b b:%b f:%b exp=0,0,0", i, valid, busy, fault); end
    end
    en = 1'b1;
    step(5);
    chk = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b1 || count !== 8'd1) begin n_err++; $display("FAIL en_drop_recount got=v:%b c:%0d exp=1,1", valid, count); end
  endtask

  initial begin
    test_reset();
    test_qualified();
    test_glitch();
    test_backpressure();
    test_saturation();
    test_clear();
    test_en_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_check_monitor.md
Name: cpu_check_monitor

Overview:
- Downstream consumer of a cpu instance's cpu_sig_o / cpu_checker outputs.
- Forms the raw check condition (sig AND checker) and qualifies it over QUAL_CYCLES consecutive cycles.
- On each qualified fault: counts it, timestamps it, sets a sticky flag and publishes one report over a valid/ready handshake.
- Sits beside cpu2 and replaces its raw combinational cpu2_check with a registered, debounced fault stream.

Parameters:
- QUAL_CYCLES, 4: consecutive hit cycles needed to declare a fault (legal range 1..255).
- CNT_W, 8: width of the saturating fault counter.
- TS_W, 16: width of the free-running timestamp.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  monitor enable.
- clr_i  input  1  synchronous clear of fault count and sticky flag.
- cpu_sig_i  input  1  from the cpu instance's cpu_sig_o.
- cpu_checker_i  input  1  from the cpu instance's cpu_checker.
- rpt_valid_o  output  1  report valid.
- rpt_ready_i  input  1  report accept from the consumer.
- rpt_count_o  output  CNT_W  fault count snapshot.
- rpt_ts_o  output  TS_W  timestamp of the first hit cycle of the fault.
- fault_o  output  1  sticky: at least one fault since reset or clear.
- busy_o  output  1  high in any state other than IDLE or ARMED.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: FSM=IDLE; rpt_valid_o, fault_o and busy_o = 0; counters, qual_cnt, ts and payload registers = 0. Reset asserted mid-REPORT drops rpt_valid_o immediately.
- hit = cpu_sig_i & cpu_checker_i (combinational, sampled each edge).
- Timestamp:
  - ts increments by 1 every cycle while en_i=1 and wraps 2^TS_W-1 -> 0.
  - ts holds while en_i=0.
- FSM states and transitions:
  - IDLE: go to ARMED when en_i=1.
  - ARMED at cycle t:
    - en_i=0 -> IDLE.
    - hit=1 -> capture ts_first = ts.
    - If QUAL_CYCLES==1 -> FAULT; else -> QUAL with qual_cnt=1.
  - QUAL:
    - en_i=0 -> IDLE.
    - hit=0 -> ARMED; qual_cnt cleared.
    - hit=1 -> qual_cnt+1; when the new value equals QUAL_CYCLES -> FAULT.
  - FAULT (exactly one cycle):
    - fault_cnt <= min(fault_cnt+1, 2^CNT_W-1), saturating with no wrap.
    - fault_o <= 1.
    - Payload snapshot: rpt_count_o = incremented count, rpt_ts_o = ts_first.
    - Next state: REPORT.
  - REPORT:
    - rpt_valid_o=1; payload held stable until rpt_valid_o & rpt_ready_i.
    - On accept: WAIT_LOW.
    - en_i and clr_i do not abort REPORT.
  - WAIT_LOW:
    - hit=0 -> ARMED (en_i=1) or IDLE (en_i=0).
    - Guarantees one report per continuous hit episode.
- Latency: hit first seen at cycle t and held -> FAULT at t+QUAL_CYCLES -> rpt_valid_o high at t+QUAL_CYCLES+1.
- Handshake:
  - rpt_valid_o never deasserts without acceptance (except on reset).
  - Ready may be held high early; acceptance takes one cycle. rpt_valid_o falls the cycle after the accepting edge.
- clr_i:
  - Clears fault_cnt and fault_o on the next edge. Wins over a simultaneous FAULT increment: result count=0, fault_o=0.
  - Does not alter the payload snapshot or the FSM state.
- en_i falling in QUAL discards the partial qualification; no fault is counted.

Decomposition:
- Package cpu_mon_pkg holds:
  - typedef enum state_e {IDLE, ARMED, QUAL, FAULT, REPORT, WAIT_LOW}.
  - Default constants DEF_QUAL_CYCLES=4, DEF_CNT_W=8, DEF_TS_W=16.
- Single module, no sub-module. The qualification counter is too small to justify one.

Test Plan (QUAL_CYCLES=4, CNT_W=8, TS_W=16 unless noted):
- Reset: hold rst_n=0 with en_i=1 and hit=1 -> rpt_valid_o=0, fault_o=0, busy_o=0, rpt_count_o=0.
- Qualified fault: en_i=1, hit rises when ts=10 and is held 4 cycles, rpt_ready_i=1 -> rpt_valid_o high 5 cycles after the first hit for 1 cycle, rpt_count_o=1, rpt_ts_o=10, fault_o=1.
- Glitch rejection: hit high 3 cycles then low -> no rpt_valid_o, fault_o=0; a second 4-cycle episode reports rpt_count_o=1.
- Backpressure: rpt_ready_i=0 for 6 cycles after rpt_valid_o -> valid and payload stable all 6 cycles; raise ready -> single accept, then WAIT_LOW until hit falls.
- Saturation (CNT_W=2): 5 separated qualified episodes -> reported counts 1, 2, 3, 3, 3.
- Clear vs. increment: pulse clr_i in the FAULT cycle -> fault_cnt=0, fault_o=0, but the in-flight report still shows rpt_count_o=1. Async reset mid-REPORT -> rpt_valid_o=0 immediately.
